// File: rtl/nios_sys_hex_pkg.sv
// Shared types, segment patterns and time-of-day helpers for the hex clock master.
package nios_sys_hex_pkg;

  typedef logic [6:0] seg_t;

  // Active-high patterns, bit0=a .. bit6=g
  localparam seg_t SEG_0 = 7'h3F;
  localparam seg_t SEG_1 = 7'h06;
  localparam seg_t SEG_2 = 7'h5B;
  localparam seg_t SEG_3 = 7'h4F;
  localparam seg_t SEG_4 = 7'h66;
  localparam seg_t SEG_5 = 7'h6D;
  localparam seg_t SEG_6 = 7'h7D;
  localparam seg_t SEG_7 = 7'h07;
  localparam seg_t SEG_8 = 7'h7F;
  localparam seg_t SEG_9 = 7'h6F;

  typedef enum logic [2:0] {HEX0, HEX1, HEX2, HEX3, HEX4, HEX5} hex_idx_e;
  typedef enum logic {IDLE, WRITE} state_e;

  typedef struct packed {
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
  } tod_t;

  function automatic logic tod_valid(input tod_t t);
    logic hh_ok, mm_ok, ss_ok;
    hh_ok = (t.hh[7:4] < 4'd2 && t.hh[3:0] <= 4'd9) ||
            (t.hh[7:4] == 4'd2 && t.hh[3:0] <= 4'd3);
    mm_ok = t.mm[7:4] <= 4'd5 && t.mm[3:0] <= 4'd9;
    ss_ok = t.ss[7:4] <= 4'd5 && t.ss[3:0] <= 4'd9;
    return hh_ok && mm_ok && ss_ok;
  endfunction

  // One-second BCD advance with ripple carry through mm and hh.
  function automatic tod_t tod_inc(input tod_t t);
    tod_t r;
    r = t;
    if (t.ss[3:0] != 4'd9) r.ss[3:0] = t.ss[3:0] + 4'd1;
    else begin
      r.ss[3:0] = 4'd0;
      if (t.ss[7:4] != 4'd5) r.ss[7:4] = t.ss[7:4] + 4'd1;
      else begin
        r.ss[7:4] = 4'd0;
        if (t.mm[3:0] != 4'd9) r.mm[3:0] = t.mm[3:0] + 4'd1;
        else begin
          r.mm[3:0] = 4'd0;
          if (t.mm[7:4] != 4'd5) r.mm[7:4] = t.mm[7:4] + 4'd1;
          else begin
            r.mm[7:4] = 4'd0;
            if (t.hh == 8'h23) r.hh = 8'h00;
            else if (t.hh[3:0] == 4'd9) r.hh = {t.hh[7:4] + 4'd1, 4'd0};
            else r.hh[3:0] = t.hh[3:0] + 4'd1;
          end
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/nios_sys_bcd_to_seg7.sv
// Combinational BCD digit to 7-segment decoder; non-decimal codes blank the digit.
module nios_sys_bcd_to_seg7 import nios_sys_hex_pkg::*; #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] bcd,
  output seg_t       seg
);

  seg_t raw;

  always_comb begin
    raw = '0;
    case (bcd)
      4'd0: raw = SEG_0;
      4'd1: raw = SEG_1;
      4'd2: raw = SEG_2;
      4'd3: raw = SEG_3;
      4'd4: raw = SEG_4;
      4'd5: raw = SEG_5;
      4'd6: raw = SEG_6;
      4'd7: raw = SEG_7;
      4'd8: raw = SEG_8;
      4'd9: raw = SEG_9;
      default: raw = '0;
    endcase
  end

  assign seg = ACTIVE_LOW ? ~raw : raw;

endmodule

// File: rtl/nios_sys_hex_clock_master.sv
// Free-running HH:MM:SS clock that refreshes six hex PIO slaves via Avalon-MM write bursts.
module nios_sys_hex_clock_master import nios_sys_hex_pkg::*; #(
  parameter int          CLK_HZ         = 50_000_000,
  parameter int          ADDR_W         = 32,
  parameter logic [31:0] HEX_BASE       = 32'h0000_1000,
  parameter logic [31:0] HEX_STRIDE     = 32'h10,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              set,
  input  logic [7:0]        set_hh,
  input  logic [7:0]        set_mm,
  input  logic [7:0]        set_ss,
  output logic [ADDR_W-1:0] address,
  output logic              write,
  output logic [31:0]       writedata,
  input  logic              waitrequest,
  output logic              busy
);

  localparam int             PW     = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0]  PRE_TC = PW'(CLK_HZ - 1);

  logic [PW-1:0]   pre_cnt;
  tod_t            tod, set_tod;
  logic            tick, load, pending, take;
  state_e          state, state_nxt;
  hex_idx_e        idx, idx_nxt;
  logic            write_nxt;
  logic [5:0][3:0] snap;
  seg_t            seg;

  assign set_tod = {set_hh, set_mm, set_ss};
  assign tick    = run && (pre_cnt == PRE_TC);
  assign load    = set && tod_valid(set_tod);
  assign take    = (state == IDLE) && pending;
  assign busy    = (state != IDLE);

  // A valid load pre-empts a same-cycle tick; an invalid set leaves everything alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt <= '0;
      tod     <= '0;
      pending <= 1'b1;
    end else begin
      if (load) begin
        tod     <= set_tod;
        pre_cnt <= '0;
      end else begin
        if (run)  pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
        if (tick) tod <= tod_inc(tod);
      end
      if (load || tick) pending <= 1'b1;
      else if (take)    pending <= 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    write_nxt = write;
    case (state)
      IDLE: begin
        if (pending) begin
          state_nxt = WRITE;
          idx_nxt   = HEX0;
        end
      end
      WRITE: begin
        if (!write) write_nxt = 1'b1;
        else if (!waitrequest) begin
          if (idx == HEX5) begin
            state_nxt = IDLE;
            write_nxt = 1'b0;
          end else begin
            idx_nxt = hex_idx_e'(idx + 3'd1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Decode ahead on idx_nxt so address/data register alongside write.
  nios_sys_bcd_to_seg7 #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg (
    .bcd (snap[idx_nxt]),
    .seg (seg)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= HEX0;
      write     <= 1'b0;
      address   <= '0;
      writedata <= '0;
      snap      <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      write <= write_nxt;
      if (take) snap <= {tod.hh, tod.mm, tod.ss};
      if (write_nxt) begin
        address   <= ADDR_W'(HEX_BASE) + ADDR_W'(HEX_STRIDE) * ADDR_W'(idx_nxt);
        writedata <= {25'b0, seg};
      end
    end
  end

endmodule

// File: tb/tb_nios_sys_hex_clock_master.sv
// Directed bench for the hex clock master: burst contents, stalls, tick/set interplay and reset.
module tb_nios_sys_hex_clock_master;

  localparam int          CLK_HZ = 4;
  localparam logic [31:0] BASE   = 32'h1000;
  localparam logic [31:0] STRIDE = 32'h10;

  // Expected active-low segments, HEX5 (hh tens) first
  localparam logic [5:0][6:0] E_000000 = {6{7'h40}};
  localparam logic [5:0][6:0] E_123456 = {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02};
  localparam logic [5:0][6:0] E_123457 = {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h78};
  localparam logic [5:0][6:0] E_235959 = {7'h24, 7'h30, 7'h12, 7'h10, 7'h12, 7'h10};

  logic        clk = 1'b0, reset = 1'b1, run = 1'b0, set = 1'b0, waitrequest = 1'b0;
  logic [7:0]  set_hh = '0, set_mm = '0, set_ss = '0;
  logic [31:0] address, writedata;
  logic        write, busy;

  int checks = 0, errors = 0;
  logic [31:0] acc_addr[$];
  logic [31:0] acc_data[$];

  typedef struct {
    logic [7:0]      hh, mm, ss;
    bit              valid;
    logic [5:0][6:0] seg;
  } vec_t;
  vec_t vt[8];

  always #5 clk = ~clk;

  nios_sys_hex_clock_master #(
    .CLK_HZ(CLK_HZ), .ADDR_W(32), .HEX_BASE(BASE), .HEX_STRIDE(STRIDE), .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .set(set),
    .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss),
    .address(address), .write(write), .writedata(writedata),
    .waitrequest(waitrequest), .busy(busy)
  );

  always @(posedge clk)
    if (write && !waitrequest) begin
      acc_addr.push_back(address);
      acc_data.push_back(writedata);
    end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_acc();
    acc_addr.delete();
    acc_data.delete();
  endtask

  task automatic pulse_set(input logic [7:0] hh, input logic [7:0] mm, input logic [7:0] ss);
    set_hh = hh; set_mm = mm; set_ss = ss; set = 1'b1;
    @(negedge clk);
    set = 1'b0;
  endtask

  task automatic wait_acc(input int n, input string name);
    for (int i = 0; i < 40 && acc_addr.size() < n; i++) @(negedge clk);
    if (acc_addr.size() < n) begin
      checks++; errors++;
      $display("FAIL %s timeout: got %0d transfers expected %0d", name, acc_addr.size(), n);
    end
  endtask

  task automatic wait_write_to(input logic [31:0] a, input string name);
    int n = 0;
    while (!(write && address == a) && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk({name, " reach"}, {31'b0, write && address == a}, 32'd1);
  endtask

  task automatic check_burst(input int base, input logic [5:0][6:0] exp, input string name);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("%s addr%0d", name, k), acc_addr[base+k], BASE + STRIDE * k);
      chk($sformatf("%s data%0d", name, k), acc_data[base+k], {25'b0, exp[k]});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int gap;
    vt[0] = '{hh:8'h12, mm:8'h34, ss:8'h56, valid:1'b1, seg:E_123456};
    vt[1] = '{hh:8'h09, mm:8'h58, ss:8'h07, valid:1'b1,
              seg:{7'h40, 7'h10, 7'h12, 7'h00, 7'h40, 7'h78}};
    vt[2] = '{hh:8'h24, mm:8'h00, ss:8'h00, valid:1'b0, seg:E_000000};
    vt[3] = '{hh:8'h20, mm:8'h19, ss:8'h08, valid:1'b1,
              seg:{7'h24, 7'h40, 7'h79, 7'h10, 7'h40, 7'h00}};
    vt[4] = '{hh:8'h12, mm:8'h60, ss:8'h00, valid:1'b0, seg:E_000000};
    vt[5] = '{hh:8'h00, mm:8'h00, ss:8'h5A, valid:1'b0, seg:E_000000};
    vt[6] = '{hh:8'h1A, mm:8'h00, ss:8'h00, valid:1'b0, seg:E_000000};
    vt[7] = '{hh:8'h23, mm:8'h59, ss:8'h59, valid:1'b1, seg:E_235959};

    // Reset state
    cyc(2);
    chk("rst write", {31'b0, write}, 32'd0);
    chk("rst busy", {31'b0, busy}, 32'd0);
    chk("rst address", address, 32'd0);
    chk("rst writedata", writedata, 32'd0);

    // Initial refresh: 2-cycle latency then six back-to-back writes of '0'
    reset = 1'b0;
    @(negedge clk);
    chk("init lat write", {31'b0, write}, 32'd0);
    chk("init lat busy", {31'b0, busy}, 32'd1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("init write%0d", k), {31'b0, write}, 32'd1);
      chk($sformatf("init addr%0d", k), address, BASE + STRIDE * k);
      chk($sformatf("init data%0d", k), writedata, 32'h40);
    end
    @(negedge clk);
    chk("init end write", {31'b0, write}, 32'd0);
    chk("init end busy", {31'b0, busy}, 32'd0);
    cyc(2);

    // 23:59:59 then one tick rolls over to 00:00:00
    clear_acc();
    pulse_set(8'h23, 8'h59, 8'h59);
    wait_acc(6, "set235959");
    check_burst(0, E_235959, "set235959");
    cyc(3);
    clear_acc();
    run = 1'b1;
    for (int i = 0; i < 20 && !write; i++) @(negedge clk);
    run = 1'b0;
    wait_acc(6, "rollover");
    check_burst(0, E_000000, "rollover");
    cyc(4);
    chk("rollover count", acc_addr.size(), 32'd6);

    // Stall 3 cycles on the HEX1 write
    clear_acc();
    pulse_set(8'h12, 8'h34, 8'h56);
    wait_write_to(BASE + STRIDE, "stall");
    waitrequest = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("stall hold addr%0d", k), address, BASE + STRIDE);
      chk($sformatf("stall hold data%0d", k), writedata, 32'h12);
      chk($sformatf("stall hold write%0d", k), {31'b0, write}, 32'd1);
    end
    waitrequest = 1'b0;
    wait_acc(6, "stall");
    cyc(4);
    chk("stall count", acc_addr.size(), 32'd6);
    check_burst(0, E_123456, "stall");

    // Tick during a stalled burst: old snapshot, then one follow-up burst
    clear_acc();
    waitrequest = 1'b1;
    run = 1'b1;
    pulse_set(8'h12, 8'h34, 8'h56);
    for (int i = 0; i < 20 && !write; i++) @(negedge clk);
    cyc(3);
    run = 1'b0;
    waitrequest = 1'b0;
    wait_acc(6, "midtick first");
    gap = 0;
    while (!write && gap < 10) begin
      @(negedge clk);
      gap++;
    end
    chk("midtick gap", gap, 32'd2);
    wait_acc(12, "midtick second");
    cyc(4);
    chk("midtick count", acc_addr.size(), 32'd12);
    check_burst(0, E_123456, "midtick first");
    check_burst(6, E_123457, "midtick second");

    // Set on the same cycle as a tick: set wins
    clear_acc();
    pulse_set(8'h00, 8'h00, 8'h00);
    wait_acc(6, "pre-tie");
    cyc(4);
    clear_acc();
    run = 1'b1;
    cyc(3);
    set_hh = 8'h12; set_mm = 8'h34; set_ss = 8'h56; set = 1'b1;
    @(negedge clk);
    set = 1'b0;
    run = 1'b0;
    wait_acc(6, "tie");
    cyc(4);
    chk("tie count", acc_addr.size(), 32'd6);
    check_burst(0, E_123456, "tie");
    clear_acc();
    pulse_set(8'h12, 8'h60, 8'h56);
    cyc(12);
    chk("bad mm count", acc_addr.size(), 32'd0);
    chk("bad mm busy", {31'b0, busy}, 32'd0);

    // Table of loads: valid ones produce one burst, invalid ones none
    for (int i = 0; i < 8; i++) begin
      clear_acc();
      pulse_set(vt[i].hh, vt[i].mm, vt[i].ss);
      if (vt[i].valid) begin
        wait_acc(6, $sformatf("vec%0d", i));
        cyc(4);
        chk($sformatf("vec%0d count", i), acc_addr.size(), 32'd6);
        check_burst(0, vt[i].seg, $sformatf("vec%0d", i));
      end else begin
        cyc(12);
        chk($sformatf("vec%0d count", i), acc_addr.size(), 32'd0);
      end
    end

    // Reset mid-burst at HEX3
    clear_acc();
    pulse_set(8'h09, 8'h58, 8'h07);
    wait_write_to(BASE + 3 * STRIDE, "midrst");
    #2 reset = 1'b1;
    #1;
    chk("midrst write", {31'b0, write}, 32'd0);
    chk("midrst busy", {31'b0, busy}, 32'd0);
    chk("midrst address", address, 32'd0);
    @(negedge clk);
    clear_acc();
    reset = 1'b0;
    wait_acc(6, "postrst");
    cyc(4);
    chk("postrst count", acc_addr.size(), 32'd6);
    check_burst(0, E_000000, "postrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
